// File: rtl/snake_pkg.sv
// snake_pkg: types and constants shared by the snake motion block and its
// interface.
//   dir_t   : committed / requested travel direction (UP=0, DOWN=1, LEFT=2, RIGHT=3)
//   state_t : play state machine (IDLE, RUN, DEAD)
//   screen size, cell pitch and history slot width
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int CELL     = 10;
  localparam int SLOT_W   = 10;

  // Direction the head would have to reverse into; such requests are dropped.
  function automatic dir_t opposite_dir(input dir_t d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      RIGHT:   return LEFT;
      default: return LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_motion_if.sv
// snake_motion_if: control inputs and position/score outputs of snake_motion.
//   master modport: producer of start/buttons/eat/GameOver, consumer of the outputs
//   slave modport : snake_motion side
//   start, btn_*, eat, GameOver : 1-bit controls
//   snakex/snakey : head position, SLOT_W bits each
//   storex/storey : SLOTS x SLOT_W history, slot k at [SLOT_W*k +: SLOT_W]
//   score (8 bits), running (1 bit)
interface snake_motion_if #(
  parameter int SLOTS = 20
);
  import snake_pkg::*;

  logic                      start;
  logic                      btn_up;
  logic                      btn_down;
  logic                      btn_left;
  logic                      btn_right;
  logic                      eat;
  logic                      GameOver;
  logic [SLOT_W-1:0]         snakex;
  logic [SLOT_W-1:0]         snakey;
  logic [SLOTS*SLOT_W-1:0]   storex;
  logic [SLOTS*SLOT_W-1:0]   storey;
  logic [7:0]                score;
  logic                      running;

  modport master (
    output start, btn_up, btn_down, btn_left, btn_right, eat, GameOver,
    input  snakex, snakey, storex, storey, score, running
  );

  modport slave (
    input  start, btn_up, btn_down, btn_left, btn_right, eat, GameOver,
    output snakex, snakey, storex, storey, score, running
  );

endinterface

// File: rtl/snake_motion_step_timer.sv
// step_timer: free-running divider that paces game steps.
//   vga_clk : clock
//   reset   : synchronous active-high reset
//   enable  : count while high
//   clear   : force the count to zero (wins over enable)
//   tick    : high for the one cycle in which the count equals STEP_DIV-1
module step_timer #(
  parameter int STEP_DIV = 2500000
) (
  input  logic vga_clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int               CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_q;
  logic             tick_d;

  // Next count; tick is registered from the next count so it lines up with cnt_q.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
    tick_d = (cnt_d == LAST);
  end

  // Counter and tick registers.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/snake_motion.sv
// snake_motion: moves the snake head one cell per game step, keeps the
// position history and score, and freezes on GameOver.
//   vga_clk : clock
//   reset   : synchronous active-high reset
//   bus     : snake_motion_if slave (controls in; snakex/snakey/storex/storey/
//             score/running out, all registered)
module snake_motion
  import snake_pkg::*;
#(
  parameter int STEP_DIV  = 2500000,
  parameter int CELL      = snake_pkg::CELL,
  parameter int START_X   = SCREEN_W / 2,
  parameter int START_Y   = SCREEN_H / 2,
  parameter int SLOTS     = 20,
  parameter int MAX_SCORE = SLOTS - 2
) (
  input  logic          vga_clk,
  input  logic          reset,
  snake_motion_if.slave bus
);

  localparam int                HIST_W   = SLOTS * SLOT_W;
  localparam logic [SLOT_W-1:0] CELL_V   = SLOT_W'(CELL);
  localparam logic [SLOT_W-1:0] START_XV = SLOT_W'(START_X);
  localparam logic [SLOT_W-1:0] START_YV = SLOT_W'(START_Y);
  localparam logic [HIST_W-1:0] HIST_X0  = {SLOTS{START_XV}};
  localparam logic [HIST_W-1:0] HIST_Y0  = {SLOTS{START_YV}};
  localparam logic [7:0]        MAX_V    = 8'(MAX_SCORE);

  state_t            state_q,  state_d;
  dir_t              dir_q,    dir_d;
  dir_t              next_dir_q, next_dir_d;
  logic              grow_q,   grow_d;
  logic [SLOT_W-1:0] snakex_q, snakex_d;
  logic [SLOT_W-1:0] snakey_q, snakey_d;
  logic [HIST_W-1:0] storex_q, storex_d;
  logic [HIST_W-1:0] storey_q, storey_d;
  logic [7:0]        score_q,  score_d;
  logic              running_q, running_d;

  logic              tick;
  logic              req_vld;
  dir_t              req_dir;
  dir_t              sampled_dir;
  logic              grow_now;
  logic [SLOT_W-1:0] head_x;
  logic [SLOT_W-1:0] head_y;

  // Counter only advances in RUN and sits at zero elsewhere, so entry into RUN
  // always starts a fresh step.
  step_timer #(
    .STEP_DIV(STEP_DIV)
  ) u_step_timer (
    .vga_clk(vga_clk),
    .reset  (reset),
    .enable (state_q == RUN),
    .clear  (state_q != RUN),
    .tick   (tick)
  );

  // Button priority up > down > left > right; reversal checked against the
  // committed direction so two turns in one step cannot fold back.
  always_comb begin
    req_vld = 1'b1;
    req_dir = RIGHT;
    if (bus.btn_up) begin
      req_dir = UP;
    end else if (bus.btn_down) begin
      req_dir = DOWN;
    end else if (bus.btn_left) begin
      req_dir = LEFT;
    end else if (bus.btn_right) begin
      req_dir = RIGHT;
    end else begin
      req_vld = 1'b0;
    end
    if (req_vld && (req_dir != opposite_dir(dir_q))) begin
      sampled_dir = req_dir;
    end else begin
      sampled_dir = next_dir_q;
    end
  end

  // Candidate head for this step; 10-bit wraparound is intentional.
  always_comb begin
    head_x = snakex_q;
    head_y = snakey_q;
    case (sampled_dir)
      UP:      head_y = snakey_q - CELL_V;
      DOWN:    head_y = snakey_q + CELL_V;
      LEFT:    head_x = snakex_q - CELL_V;
      RIGHT:   head_x = snakex_q + CELL_V;
      default: head_x = snakex_q;
    endcase
  end

  assign grow_now = grow_q | bus.eat;

  // Play FSM, step move, history shift and scoring.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    next_dir_d = next_dir_q;
    grow_d     = grow_q;
    snakex_d   = snakex_q;
    snakey_d   = snakey_q;
    storex_d   = storex_q;
    storey_d   = storey_q;
    score_d    = score_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // GameOver wins over a same-cycle tick: nothing moves on that edge.
        if (bus.GameOver) begin
          state_d = DEAD;
        end else begin
          state_d    = RUN;
          next_dir_d = sampled_dir;
          grow_d     = grow_now;
          if (tick) begin
            dir_d    = sampled_dir;
            snakex_d = head_x;
            snakey_d = head_y;
            storex_d = {storex_q[HIST_W-SLOT_W-1:0], head_x};
            storey_d = {storey_q[HIST_W-SLOT_W-1:0], head_y};
            grow_d   = 1'b0;
            if (grow_now && (score_q < MAX_V)) begin
              score_d = score_q + 8'd1;
            end else begin
              score_d = score_q;
            end
          end else begin
            dir_d = dir_q;
          end
        end
      end
      DEAD: begin
        if (bus.start) begin
          state_d    = IDLE;
          dir_d      = RIGHT;
          next_dir_d = RIGHT;
          grow_d     = 1'b0;
          snakex_d   = START_XV;
          snakey_d   = START_YV;
          storex_d   = HIST_X0;
          storey_d   = HIST_Y0;
          score_d    = 8'd0;
        end else begin
          state_d = DEAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    running_d = (state_d == RUN);
  end

  // State and output registers.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dir_q      <= RIGHT;
      next_dir_q <= RIGHT;
      grow_q     <= 1'b0;
      snakex_q   <= START_XV;
      snakey_q   <= START_YV;
      storex_q   <= HIST_X0;
      storey_q   <= HIST_Y0;
      score_q    <= 8'd0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      next_dir_q <= next_dir_d;
      grow_q     <= grow_d;
      snakex_q   <= snakex_d;
      snakey_q   <= snakey_d;
      storex_q   <= storex_d;
      storey_q   <= storey_d;
      score_q    <= score_d;
      running_q  <= running_d;
    end
  end

  assign bus.snakex  = snakex_q;
  assign bus.snakey  = snakey_q;
  assign bus.storex  = storex_q;
  assign bus.storey  = storey_q;
  assign bus.score   = score_q;
  assign bus.running = running_q;

endmodule

// File: doc/snake_motion.md
Name: snake_motion

Overview:
- Upstream producer for the collision/game-over stage.
- Each game step it moves the snake head one grid cell in the latched direction and shifts the previous head positions into the position history.
- It tracks score/length and freezes when game-over is asserted.
- Outputs are snakex, snakey, storex, storey and score, formatted for direct consumption by the collision checker.

Parameters:
- STEP_DIV, 2500000, vga_clk cycles per game step (10 Hz at 25 MHz); minimum 2.
- CELL, 10, pixels moved per step.
- START_X, 320, head x after reset/start.
- START_Y, 240, head y after reset/start.
- SLOTS, 20, number of 10-bit history slots in storex/storey.
- MAX_SCORE, 18, score saturation value (SLOTS-2).

Ports:
- vga_clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level; begins play from IDLE
- btn_up  in  1  direction request, level
- btn_down  in  1  direction request, level
- btn_left  in  1  direction request, level
- btn_right  in  1  direction request, level
- eat  in  1  one-cycle pulse: head reached food
- GameOver  in  1  from collision stage; freezes motion
- snakex  out  10  head x, pixels
- snakey  out  10  head y, pixels
- storex  out  200  x history; slot k = bits [10k+9:10k]
- storey  out  200  y history, same layout
- score  out  8  food eaten, saturating
- running  out  1  high in RUN state

Behaviour:
- Clocking and reset:
  - One clock: vga_clk. Reset is synchronous and active-high.
  - Reset gives: state IDLE, snakex=START_X, snakey=START_Y, every storex/storey slot = START_X/START_Y, score=0, dir=RIGHT, step counter=0, grow_pending=0, running=0.
- States:
  - IDLE -> RUN when start=1. The step counter clears on entry.
  - RUN -> DEAD when GameOver=1. The check happens every cycle and takes priority over a same-cycle step, so no move occurs in that cycle.
  - DEAD -> IDLE when start=1. All outputs reload their reset values on this transition.
  - In IDLE and DEAD all outputs hold; in DEAD the last positions stay visible.
- Step tick:
  - Counter runs only in RUN and counts 0..STEP_DIV-1.
  - tick=1 for the single cycle in which counter==STEP_DIV-1; counter then wraps to 0.
- Direction latch:
  - Sampled every RUN cycle into next_dir.
  - Priority when several buttons are high: up > down > left > right.
  - A request opposite to the committed dir is ignored (e.g. LEFT while moving RIGHT).
  - next_dir commits to dir on tick.
  - The reversal check is against the committed dir, not next_dir, so two turns within one step cannot produce a reversal.
- Move on tick (outputs update at the clock edge ending the tick cycle, i.e. latency 1):
  - new head = head ± CELL on the dir axis. UP decreases y; RIGHT increases x.
  - Arithmetic is 10-bit modulo 1024 with no clamping: left from x=0 gives 1014, which the downstream stage flags as out-of-range.
  - History shift: slot[i] <= slot[i-1] for i=SLOTS-1..1, then slot[0] <= new head. Slot 0 therefore always equals snakex/snakey, slot 1 is the previous head, and slots 2.. are body segments.
- Scoring:
  - An eat pulse in RUN sets grow_pending.
  - On the next tick: score <= min(score+1, MAX_SCORE), grow_pending clears.
  - If eat and tick fall in the same cycle, growth applies on that tick.
  - Multiple eats before one tick count once.
  - At MAX_SCORE, eat is accepted but score stays 18.
- Reset asserted mid-step: all state reloads on that edge and the partial step count is discarded.

Decomposition:
- Shared package snake_pkg holds:
  - dir_t 2-bit enum: UP=0, DOWN=1, LEFT=2, RIGHT=3.
  - SCREEN_W=640, SCREEN_H=480, CELL=10, SLOT_W=10.
  - state_t: IDLE, RUN, DEAD.
- One sub-module, step_timer: parameter STEP_DIV; ports vga_clk, reset, enable, clear, tick.
- Direction latch, history shifter and FSM stay in snake_motion.

Test Plan:
- Run all tests with STEP_DIV=4.
- Reset, start, 3 ticks with no buttons -> snakex=350, snakey=240; slot0=(350,240), slot1=(340,240), slot2=(330,240); tick spacing exactly 4 cycles.
- Moving RIGHT, pulse btn_left then btn_up within one step -> next tick moves up (x unchanged, y=230); LEFT is never taken.
- btn_up and btn_right held together while moving LEFT -> UP taken; then press btn_down while moving UP -> ignored, y keeps decreasing by 10.
- eat pulse on the same cycle as a tick -> score 0->1 at that edge. Then 25 eats spread across 25 steps -> score saturates at 18.
- Start at x=20 moving LEFT, 3 ticks -> snakex 10, 0, 1014. Then assert GameOver -> state DEAD, positions frozen across further cycles.
- reset asserted 2 cycles into a step while in RUN -> next cycle all outputs are at reset values, running=0, and the next start produces its first tick exactly 4 cycles later.
